// File: rtl/win_pkg.sv
// Shared widths, frame geometry defaults and helpers for the 3x3 window filter
// and the window generator that feeds it.
package win_pkg;
    localparam int LINE_LEN_DEF = 1025;
    localparam int ACT_W_DEF    = 1024;
    localparam int ROWS_DEF     = 1024;

    localparam int PIX_W   = 14;
    localparam int COEF_W  = 8;
    localparam int COORD_W = 11;
    localparam int IDX_W   = 4;
    localparam int SHIFT_W = 4;
    localparam int RES_W   = 8;
    localparam int NTAPS   = 9;
    localparam int PROD_W  = 23;
    localparam int ROW_W   = 25;
    localparam int SUM_W   = 27;

    typedef struct packed {
        logic               valid;
        logic               last;
        logic [COORD_W-1:0] col;
        logic [COORD_W-1:0] row;
    } tag_t;

    // Clamp a signed total into the unsigned 8-bit pixel range.
    function automatic logic [RES_W-1:0] sat_u8(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1])
            return '0;
        else if (|v[SUM_W-2:RES_W])
            return '1;
        else
            return v[RES_W-1:0];
    endfunction
endpackage

// File: rtl/win_conv3x3_if.sv
// Window-in / result-out bundle of the 3x3 convolution block.
interface win_conv3x3_if;
    import win_pkg::*;

    logic                     en_window;
    logic [PIX_W-1:0]         pix_00, pix_01, pix_02;
    logic [PIX_W-1:0]         pix_10, pix_11, pix_12;
    logic [PIX_W-1:0]         pix_20, pix_21, pix_22;
    logic                     frame_start;
    logic                     coef_load;
    logic [IDX_W-1:0]         coef_idx;
    logic signed [COEF_W-1:0] coef_data;
    logic [SHIFT_W-1:0]       shift;
    logic [RES_W-1:0]         res_data;
    logic                     res_valid;
    logic [COORD_W-1:0]       res_col;
    logic [COORD_W-1:0]       res_row;
    logic                     frame_done;

    modport master (
        output en_window, pix_00, pix_01, pix_02, pix_10, pix_11, pix_12,
               pix_20, pix_21, pix_22, frame_start, coef_load, coef_idx,
               coef_data, shift,
        input  res_data, res_valid, res_col, res_row, frame_done
    );

    modport slave (
        input  en_window, pix_00, pix_01, pix_02, pix_10, pix_11, pix_12,
               pix_20, pix_21, pix_22, frame_start, coef_load, coef_idx,
               coef_data, shift,
        output res_data, res_valid, res_col, res_row, frame_done
    );
endinterface

// File: rtl/win_mac9.sv
// Nine-tap multiply / row-sum / total datapath with coefficient store,
// shift and saturation; two register stages plus a combinational final stage.
module win_mac9
    import win_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIX_W-1:0]         i_pix [NTAPS],
    input  logic                     i_coef_load,
    input  logic [IDX_W-1:0]         i_coef_idx,
    input  logic signed [COEF_W-1:0] i_coef_data,
    input  logic [SHIFT_W-1:0]       i_shift,
    output logic [RES_W-1:0]         o_sat
);
    logic signed [COEF_W-1:0] r_coef [NTAPS];
    logic [SHIFT_W-1:0]       r_shift;
    logic signed [PROD_W-1:0] r_prod [NTAPS];
    logic signed [ROW_W-1:0]  r_row  [3];
    logic signed [SUM_W-1:0]  w_total;
    logic signed [SUM_W-1:0]  w_shifted;

    // Reset kernel is the identity (centre tap = 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++)
                r_coef[i] <= (i == 4) ? COEF_W'(1) : '0;
            r_shift <= '0;
        end else begin
            if (i_coef_load && (i_coef_idx < IDX_W'(NTAPS)))
                r_coef[i_coef_idx] <= i_coef_data;
            r_shift <= i_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++)
                r_prod[i] <= '0;
            for (int r = 0; r < 3; r++)
                r_row[r] <= '0;
        end else begin
            for (int i = 0; i < NTAPS; i++)
                r_prod[i] <= PROD_W'(signed'({1'b0, i_pix[i]})) * PROD_W'(r_coef[i]);
            for (int r = 0; r < 3; r++)
                r_row[r] <= ROW_W'(r_prod[3*r]) + ROW_W'(r_prod[3*r+1]) + ROW_W'(r_prod[3*r+2]);
        end
    end

    always_comb begin
        w_total   = SUM_W'(r_row[0]) + SUM_W'(r_row[1]) + SUM_W'(r_row[2]);
        w_shifted = w_total >>> r_shift;
    end

    assign o_sat = sat_u8(w_shifted);
endmodule

// File: rtl/win_conv3x3.sv
// 3x3 convolution on a streamed window: frame counters, interior detection and
// coordinate/valid pipelining around the win_mac9 datapath.
module win_conv3x3
    import win_pkg::*;
#(
    parameter int LINE_LEN = LINE_LEN_DEF,
    parameter int ACT_W    = ACT_W_DEF,
    parameter int ROWS     = ROWS_DEF
) (
    input logic          clk,
    input logic          rst_n,
    win_conv3x3_if.slave bus
);
    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(LINE_LEN - 1);
    localparam logic [COORD_W-1:0] ACT_LAST = COORD_W'(ACT_W - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(ROWS - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

    logic [COORD_W-1:0] r_col_cnt, r_row_cnt;
    tag_t               w_tag, r_tag1, r_tag2;
    logic [PIX_W-1:0]   w_pix [NTAPS];
    logic [RES_W-1:0]   w_sat;
    logic [RES_W-1:0]   r_res_data;
    logic               r_res_valid, r_frame_done;
    logic [COORD_W-1:0] r_res_col, r_res_row;

    assign w_pix[0] = bus.pix_00;
    assign w_pix[1] = bus.pix_01;
    assign w_pix[2] = bus.pix_02;
    assign w_pix[3] = bus.pix_10;
    assign w_pix[4] = bus.pix_11;
    assign w_pix[5] = bus.pix_12;
    assign w_pix[6] = bus.pix_20;
    assign w_pix[7] = bus.pix_21;
    assign w_pix[8] = bus.pix_22;

    // A window arriving with frame_start is column 0 and can never be interior.
    always_comb begin
        w_tag.valid = bus.en_window && !bus.frame_start &&
                      (r_col_cnt >= TWO) && (r_col_cnt <= ACT_LAST) &&
                      (r_row_cnt >= TWO) && (r_row_cnt <= ROW_LAST);
        w_tag.last  = (r_col_cnt == ACT_LAST) && (r_row_cnt == ROW_LAST);
        w_tag.col   = r_col_cnt - ONE;
        w_tag.row   = r_row_cnt - ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (bus.frame_start) begin
            r_row_cnt <= '0;
            r_col_cnt <= bus.en_window ? ONE : '0;
        end else if (bus.en_window) begin
            if (r_col_cnt == COL_LAST) begin
                r_col_cnt <= '0;
                r_row_cnt <= (r_row_cnt == ROW_LAST) ? '0 : r_row_cnt + ONE;
            end else begin
                r_col_cnt <= r_col_cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag1 <= '0;
            r_tag2 <= '0;
        end else begin
            r_tag1 <= w_tag;
            r_tag2 <= r_tag1;
            if (bus.frame_start) begin
                r_tag1.valid <= 1'b0;
                r_tag2.valid <= 1'b0;
            end
        end
    end

    // Result registers only move on a valid result, so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_res_data   <= '0;
            r_res_col    <= '0;
            r_res_row    <= '0;
        end else begin
            r_res_valid  <= r_tag2.valid && !bus.frame_start;
            r_frame_done <= r_tag2.valid && r_tag2.last && !bus.frame_start;
            if (r_tag2.valid && !bus.frame_start) begin
                r_res_data <= w_sat;
                r_res_col  <= r_tag2.col;
                r_res_row  <= r_tag2.row;
            end
        end
    end

    win_mac9 u_mac9 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pix       (w_pix),
        .i_coef_load (bus.coef_load),
        .i_coef_idx  (bus.coef_idx),
        .i_coef_data (bus.coef_data),
        .i_shift     (bus.shift),
        .o_sat       (w_sat)
    );

    assign bus.res_data   = r_res_data;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_col    = r_res_col;
    assign bus.res_row    = r_res_row;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_win_conv3x3.sv
// Directed bench for win_conv3x3 on a reduced 9x6 frame (8 active columns).
module tb_win_conv3x3;
    localparam int LINE_LEN = 9;
    localparam int ACT_W    = 8;
    localparam int ROWS     = 6;

    logic clk;
    logic rst_n;

    int nTests, nFail;
    int nValid, nRow1, nBadData, nBadCoord, nDone, doneCol, doneRow;
    int expData;

    win_conv3x3_if bus ();

    win_conv3x3 #(.LINE_LEN(LINE_LEN), .ACT_W(ACT_W), .ROWS(ROWS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nTests++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic observe();
        if (bus.res_valid === 1'b1) begin
            nValid++;
            if (bus.res_row == 1) nRow1++;
            if (int'(bus.res_data) != expData) nBadData++;
            if (bus.res_col < 1 || bus.res_col > ACT_W - 2 ||
                bus.res_row < 1 || bus.res_row > ROWS - 2) nBadCoord++;
            if (bus.frame_done === 1'b1) begin
                nDone++;
                doneCol = int'(bus.res_col);
                doneRow = int'(bus.res_row);
            end
        end else if (bus.frame_done !== 1'b0) begin
            nDone++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic clearCounts(input int data);
        nValid = 0; nRow1 = 0; nBadData = 0; nBadCoord = 0;
        nDone = 0; doneCol = -1; doneRow = -1;
        expData = data;
    endtask

    task automatic applyStimulus(input logic en, input logic [13:0] p);
        bus.en_window = en;
        bus.pix_00 = p; bus.pix_01 = p; bus.pix_02 = p;
        bus.pix_10 = p; bus.pix_11 = p; bus.pix_12 = p;
        bus.pix_20 = p; bus.pix_21 = p; bus.pix_22 = p;
        tick();
    endtask

    task automatic loadCoef(input int idx, input int val);
        bus.en_window = 1'b0;
        bus.coef_load = 1'b1;
        bus.coef_idx  = 4'(idx);
        bus.coef_data = 8'(val);
        tick();
        bus.coef_load = 1'b0;
    endtask

    task automatic frameStart();
        bus.en_window   = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    // Frame start, then windows up to and including row 2 column 2, then drain.
    task automatic firstResult(input logic [13:0] p);
        frameStart();
        clearCounts(0);
        repeat (21) applyStimulus(1'b1, p);
        repeat (3) applyStimulus(1'b0, p);
    endtask

    initial begin
        nTests = 0;
        nFail  = 0;
        clearCounts(0);
        rst_n           = 1'b1;
        bus.en_window   = 1'b0;
        bus.frame_start = 1'b0;
        bus.coef_load   = 1'b0;
        bus.coef_idx    = '0;
        bus.coef_data   = '0;
        bus.shift       = '0;
        bus.pix_00 = '0; bus.pix_01 = '0; bus.pix_02 = '0;
        bus.pix_10 = '0; bus.pix_11 = '0; bus.pix_12 = '0;
        bus.pix_20 = '0; bus.pix_21 = '0; bus.pix_22 = '0;
        #2 rst_n = 1'b0;
        #20;
        checkOutput("reset_valid", int'(bus.res_valid), 0);
        checkOutput("reset_data", int'(bus.res_data), 0);
        checkOutput("reset_col", int'(bus.res_col), 0);
        checkOutput("reset_row", int'(bus.res_row), 0);
        checkOutput("reset_done", int'(bus.frame_done), 0);
        @(negedge clk) rst_n = 1'b1;

        // Identity kernel, first result latency and coordinates.
        frameStart();
        clearCounts(100);
        repeat (20) applyStimulus(1'b1, 14'd100);
        checkOutput("ident_no_border_valid", nValid, 0);
        applyStimulus(1'b1, 14'd100);
        applyStimulus(1'b0, 14'd100);
        checkOutput("ident_valid_early", int'(bus.res_valid), 0);
        applyStimulus(1'b0, 14'd100);
        checkOutput("ident_valid", int'(bus.res_valid), 1);
        checkOutput("ident_data", int'(bus.res_data), 100);
        checkOutput("ident_col", int'(bus.res_col), 1);
        checkOutput("ident_row", int'(bus.res_row), 1);
        applyStimulus(1'b0, 14'd100);
        checkOutput("hold_valid", int'(bus.res_valid), 0);
        checkOutput("hold_data", int'(bus.res_data), 100);

        // Averaging over a full frame: border, padding column and frame_done.
        for (int i = 0; i < 9; i++) loadCoef(i, 1);
        bus.shift = 4'd3;
        frameStart();
        clearCounts(90);
        repeat (LINE_LEN * ROWS) applyStimulus(1'b1, 14'd80);
        repeat (3) applyStimulus(1'b0, 14'd80);
        checkOutput("avg_total_valid", nValid, (ACT_W - 2) * (ROWS - 2));
        checkOutput("avg_row1_valid", nRow1, ACT_W - 2);
        checkOutput("avg_bad_data", nBadData, 0);
        checkOutput("avg_bad_coord", nBadCoord, 0);
        checkOutput("avg_done_count", nDone, 1);
        checkOutput("avg_done_col", doneCol, ACT_W - 2);
        checkOutput("avg_done_row", doneRow, ROWS - 2);
        checkOutput("avg_col_cnt_wrap", int'(dut.r_col_cnt), 0);
        checkOutput("avg_row_cnt_wrap", int'(dut.r_row_cnt), 0);

        // Saturation low and high, then a plain shift.
        for (int i = 0; i < 9; i++) loadCoef(i, (i == 4) ? -1 : 0);
        bus.shift = 4'd0;
        firstResult(14'd50);
        checkOutput("sat_low_count", nValid, 1);
        checkOutput("sat_low_data", int'(bus.res_data), 0);
        loadCoef(4, 127);
        firstResult(14'd1000);
        checkOutput("sat_high_data", int'(bus.res_data), 255);
        loadCoef(4, 1);
        bus.shift = 4'd2;
        firstResult(14'd1000);
        checkOutput("shift2_data", int'(bus.res_data), 250);

        // Asynchronous reset mid-line, then restart from counters 0,0.
        frameStart();
        clearCounts(250);
        repeat (24) applyStimulus(1'b1, 14'd1000);
        checkOutput("pre_reset_valid", int'(bus.res_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_valid", int'(bus.res_valid), 0);
        checkOutput("async_data", int'(bus.res_data), 0);
        checkOutput("async_col", int'(bus.res_col), 0);
        checkOutput("async_row", int'(bus.res_row), 0);
        bus.en_window = 1'b0;
        bus.shift     = 4'd0;
        @(negedge clk) rst_n = 1'b1;
        loadCoef(9, 50);
        clearCounts(77);
        repeat (21) applyStimulus(1'b1, 14'd77);
        repeat (3) applyStimulus(1'b0, 14'd77);
        checkOutput("restart_count", nValid, 1);
        checkOutput("restart_data", int'(bus.res_data), 77);
        checkOutput("restart_col", int'(bus.res_col), 1);
        checkOutput("restart_row", int'(bus.res_row), 1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/win_conv3x3.md
WIN_CONV3X3 -- requirements
Module: win_conv3x3

Interface
REQ-001 SHALL have parameter LINE_LEN, default 1025, meaning window-generator columns per line, including the zero-padding column.
REQ-002 SHALL have parameter ACT_W, default 1024, meaning active pixel columns per line.
REQ-003 SHALL have parameter ROWS, default 1024, meaning lines per frame.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port en_window, input, 1, meaning a new window column was shifted in this cycle (window valid).
REQ-007 SHALL have ports pix_00..pix_22, input, 14 each, meaning the 3x3 window; row 2 is the newest row and column 2 is the newest column.
REQ-008 SHALL have port frame_start, input, 1, meaning a single-cycle pulse that restarts the frame.
REQ-009 SHALL have ports coef_load / coef_idx / coef_data, input, 1 / 4 / 8 signed, meaning a coefficient write strobe, index 0..8 (row-major, 00..22), and value.
REQ-010 SHALL have port shift, input, 4, meaning the right-shift amount applied to the sum; sampled every cycle.
REQ-011 SHALL have port res_data, output, 8, meaning the filtered, saturated pixel.
REQ-012 SHALL have port res_valid, output, 1, meaning res_data, res_col and res_row are valid this cycle.
REQ-013 SHALL have ports res_col / res_row, output, 11 each, meaning the coordinates of the result's centre pixel.
REQ-014 SHALL have port frame_done, output, 1, meaning a one-cycle pulse coincident with the last valid result of a frame.

Function
REQ-015 SHALL keep col_cnt and row_cnt (11 bit each) indexing the newest window column and row; each en_window increments col_cnt.
REQ-016 SHALL, on en_window with col_cnt==LINE_LEN-1, wrap col_cnt to 0 and increment row_cnt.
REQ-017 SHALL, on en_window with row_cnt==ROWS-1 and col_cnt==LINE_LEN-1, wrap row_cnt to 0.
REQ-018 SHALL, on frame_start, clear both counters and all pipeline valid bits; a simultaneous en_window counts as column 0, row 0.
REQ-019 SHALL mark a window interior when 2<=col_cnt<=ACT_W-1 and 2<=row_cnt<=ROWS-1; only interior windows produce results.
REQ-020 SHALL, for interior windows, report res_col=col_cnt-1 and res_row=row_cnt-1.
REQ-021 SHALL suppress border and padding-column windows; no res_valid is raised for them.
REQ-022 SHALL use a 3-stage, non-stalling pipeline.
REQ-023 SHALL, in stage 1, register 9 products of zero-extended pixel x signed coef (23-bit signed).
REQ-024 SHALL, in stage 2, register three row sums.
REQ-025 SHALL, in stage 3, form the 27-bit signed total, arithmetic-shift it right by shift, and saturate to 0..255.
REQ-026 SHALL raise res_valid exactly 3 cycles after an interior en_window, with back-to-back throughput of 1 result per cycle.
REQ-027 SHALL have stage 1 use the coefficient and shift values held before the edge; a coef_load in the same cycle as en_window applies from the next window.
REQ-028 SHALL ignore coef_load with coef_idx>8.
REQ-029 SHALL sample shift at stage 3.
REQ-030 SHALL raise frame_done with res_valid when res_row==ROWS-2 and res_col==ACT_W-2.
REQ-031 SHALL leave res_data, res_col and res_row holding their last values when res_valid=0.

Reset
REQ-032 SHALL, on rst_n low, immediately (asynchronously) clear counters, pipeline registers and valids, res_data, res_col, res_row, res_valid and frame_done to 0.
REQ-033 SHALL reset coefficients to identity (idx 4 = 1, others 0) and clear the stored shift to 0.
REQ-034 SHALL, after reset deassertion mid-frame, produce no results until a frame_start or counter alignment; the first results follow normal counting from 0,0.

Structure
REQ-035 SHALL place LINE_LEN, ACT_W, ROWS defaults, pixel width 14, coefficient width 8 and coordinate width 11 in shared package win_pkg, reused by the window generator.
REQ-036 SHALL implement the multiply/row-sum/total/shift/saturate datapath in sub-module win_mac9; counters, interior flagging and valid/coordinate pipelining stay in win_conv3x3.

Verification
REQ-037 SHALL verify identity kernel: all pix=100 for 3 lines -> res_data=100, first res_valid 3 cycles after the en_window with row_cnt=2, col_cnt=2, res_col=1, res_row=1.
REQ-038 SHALL verify averaging: all coefs=1, shift=3, all pix=80 -> sum 720>>3 -> res_data=90.
REQ-039 SHALL verify saturation: coef4=-1, pix_11=50 -> res_data=0; coef4=127, pix_11=1000, shift=0 -> res_data=255.
REQ-040 SHALL verify border: full 1025-column line stream -> exactly ACT_W-2 = 1022 res_valid per interior row; none for the padding column or rows 0 and 1.
REQ-041 SHALL verify frame_done: stream ROWS x LINE_LEN windows -> a single frame_done with res_row=1022 and res_col=1022; counters return to 0,0.
REQ-042 SHALL verify async reset and restart: rst_n low mid-line -> all outputs 0 immediately; coef_load of idx 9 -> no coefficient change.
